// File: rtl/prefetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// prefetch_stage_pkg
// Shared CPU types and constants for the prefetch stage:
//   virt_t                  - 32-bit virtual address
//   exception_t             - exception record carried with each fetch slot
//   prefetch_to_fetch_bus_t - one fetch slot {valid, pc, exception}
//   pfs_state_e             - prefetch FSM states
//   PFS_RESET_PC, EXC_ADEL  - reset PC and AdEL exception code
//   PFS_KSEG_CHECK          - 1 when PFS_KSEG_CHECK_EN is defined, else 0
// Optional feature macro: PFS_KSEG_CHECK_EN (user-mode access to kseg -> AdEL).
// ---------------------------------------------------------------------------
package prefetch_stage_pkg;

  typedef logic [31:0] virt_t;

  localparam virt_t      PFS_RESET_PC = 32'hBFC0_0000;
  localparam logic [4:0] EXC_ADEL     = 5'h04;

`ifdef PFS_KSEG_CHECK_EN
  localparam bit PFS_KSEG_CHECK = 1'b1;
`else
  localparam bit PFS_KSEG_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic       ex;
    logic       bd;
    logic       tlb_refill;
    logic [4:0] exccode;
    virt_t      badvaddr;
    virt_t      epc;
  } exception_t;

  typedef struct packed {
    logic       valid;
    virt_t      pc;
    exception_t exception;
  } prefetch_to_fetch_bus_t;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } pfs_state_e;

  // Base address of the 8-byte fetch pair containing pc.
  function automatic virt_t pair_base(input virt_t pc);
    return {pc[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/prefetch_stage_if.sv
// ---------------------------------------------------------------------------
// prefetch_stage_if
// Handshake and bus signals between the prefetch stage, the fetch queue and
// the ICache address port.
//   fs_allowin             - fetch queue can accept one pair
//   pfs_to_valid           - pair on bus1/bus2 transfers this cycle
//   prefetch_to_fetch_bus1 - slot 0 (pc & ~7)
//   prefetch_to_fetch_bus2 - slot 1 (pc & ~7 | 4)
//   icache_req/icache_addr - ICache address request (8-byte aligned)
//   icache_addr_ok         - ICache accepted the request this cycle
// Handshake: a pair transfers in exactly the cycle pfs_to_valid=1. With a
// valid request, that is icache_req && icache_addr_ok in the same cycle;
// icache_req may be withdrawn before addr_ok and then nothing transfers.
// Modports: master = prefetch stage, slave = fetch queue / ICache side.
// ---------------------------------------------------------------------------
interface prefetch_stage_if;
  import prefetch_stage_pkg::*;

  logic                   fs_allowin;
  logic                   pfs_to_valid;
  prefetch_to_fetch_bus_t prefetch_to_fetch_bus1;
  prefetch_to_fetch_bus_t prefetch_to_fetch_bus2;
  logic                   icache_req;
  virt_t                  icache_addr;
  logic                   icache_addr_ok;

  modport master (
    input  fs_allowin, icache_addr_ok,
    output pfs_to_valid, prefetch_to_fetch_bus1, prefetch_to_fetch_bus2,
           icache_req, icache_addr
  );

  modport slave (
    output fs_allowin, icache_addr_ok,
    input  pfs_to_valid, prefetch_to_fetch_bus1, prefetch_to_fetch_bus2,
           icache_req, icache_addr
  );
endinterface

// File: rtl/prefetch_stage_addr_check.sv
// ---------------------------------------------------------------------------
// pfs_addr_check
// Combinational fetch-address error detection.
//   i_pc_lo      - pc[1:0]; non-zero means a misaligned instruction fetch
//   i_pc_msb     - pc[31]; set for kseg addresses
//   i_user_mode  - CP0 user mode (only meaningful with PFS_KSEG_CHECK_EN)
//   o_addr_error - raise AdEL for this pair
// Macro: PFS_KSEG_CHECK_EN also flags user-mode fetches from kseg.
// ---------------------------------------------------------------------------
module pfs_addr_check
  import prefetch_stage_pkg::*;
(
  input  logic [1:0] i_pc_lo,
  input  logic       i_pc_msb,
  input  logic       i_user_mode,
  output logic       o_addr_error
);
  logic w_misaligned;
  logic w_kseg_violation;

  assign w_misaligned     = (i_pc_lo != 2'b00);
  // Folds to 0 when the kseg check is compiled out, so user_mode has no effect.
  assign w_kseg_violation = PFS_KSEG_CHECK && i_user_mode && i_pc_msb;
  assign o_addr_error     = w_misaligned || w_kseg_violation;
endmodule

// File: rtl/prefetch_stage.sv
// ---------------------------------------------------------------------------
// prefetch_stage
// Generates the fetch PC stream, issues aligned 8-byte ICache requests and
// hands each accepted pair to the fetch queue.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   flush/flush_target  - commit flush (highest priority) and restart PC
//   br_redirect/_target - BPU predicted-taken redirect
//   user_mode           - CP0 user mode (used only with PFS_KSEG_CHECK_EN)
//   pfs_if              - fetch queue + ICache handshake (master modport)
//   o_dbg_state         - current FSM state
// Macro: PFS_KSEG_CHECK_EN (user-mode kseg fetch raises AdEL).
// ---------------------------------------------------------------------------
module prefetch_stage
  import prefetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  virt_t      flush_target,
  input  logic       br_redirect,
  input  virt_t      br_redirect_target,
  input  logic       user_mode,
  prefetch_stage_if.master pfs_if,
  output pfs_state_e o_dbg_state
);
  pfs_state_e r_state;
  pfs_state_e w_next_state;
  virt_t      pc_r;
  virt_t      w_next_pc;
  logic       w_addr_error;
  logic       w_run;
  logic       w_go;
  logic       w_icache_req;
  logic       w_pfs_to_valid;
  exception_t w_exc;

  pfs_addr_check u_addr_check (
    .i_pc_lo      (pc_r[1:0]),
    .i_pc_msb     (pc_r[31]),
    .i_user_mode  (user_mode),
    .o_addr_error (w_addr_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BOOT;
      pc_r    <= PFS_RESET_PC;
    end else begin
      r_state <= w_next_state;
      pc_r    <= w_next_pc;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_BOOT:  w_next_state = S_RUN;
      S_RUN:   w_next_state = S_RUN;
      default: w_next_state = S_BOOT;
    endcase
  end

  always_comb begin
    w_run          = 1'b0;
    w_go           = 1'b0;
    w_icache_req   = 1'b0;
    w_pfs_to_valid = 1'b0;
    w_exc          = '0;
    w_next_pc      = pc_r;

    // Outputs stay quiet while reset is asserted, even before the edge that
    // actually returns the FSM to S_BOOT.
    w_run = (r_state == S_RUN) && !reset;
    w_go  = w_run && pfs_if.fs_allowin && !flush;

    // An errored pair needs no ICache data; it is handed over directly.
    w_icache_req   = w_go && !w_addr_error;
    w_pfs_to_valid = (w_icache_req && pfs_if.icache_addr_ok) || (w_go && w_addr_error);

    if (w_addr_error) begin
      w_exc.ex       = 1'b1;
      w_exc.exccode  = EXC_ADEL;
      w_exc.badvaddr = pc_r;
    end

    // Redirect may coincide with a transfer: the current pair still goes out.
    if (flush)               w_next_pc = flush_target;
    else if (br_redirect)    w_next_pc = br_redirect_target;
    else if (w_pfs_to_valid) w_next_pc = {pc_r[31:3] + 29'd1, 3'b000};
    else                     w_next_pc = pc_r;
  end

  always_comb begin
    pfs_if.prefetch_to_fetch_bus1 = '0;
    pfs_if.prefetch_to_fetch_bus2 = '0;
    if (w_run) begin
      pfs_if.prefetch_to_fetch_bus1.valid     = !pc_r[2];
      pfs_if.prefetch_to_fetch_bus1.pc        = pair_base(pc_r);
      pfs_if.prefetch_to_fetch_bus1.exception = w_exc;
      pfs_if.prefetch_to_fetch_bus2.valid     = 1'b1;
      pfs_if.prefetch_to_fetch_bus2.pc        = {pc_r[31:3], 3'b100};
      pfs_if.prefetch_to_fetch_bus2.exception = w_exc;
    end
  end

  assign pfs_if.icache_req   = w_icache_req;
  assign pfs_if.icache_addr  = pair_base(pc_r);
  assign pfs_if.pfs_to_valid = w_pfs_to_valid;
  assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_prefetch_stage
// Directed bench for prefetch_stage. Inputs are driven at the falling edge,
// outputs are checked 1ns later, so every check sees the state registered at
// the previous rising edge together with this cycle's inputs.
// ---------------------------------------------------------------------------
module tb_prefetch_stage;
  import prefetch_stage_pkg::*;

  logic       clk;
  logic       reset;
  logic       flush;
  virt_t      flush_target;
  logic       br_redirect;
  virt_t      br_redirect_target;
  logic       user_mode;
  pfs_state_e dbg_state;

  int checks;
  int failures;

  prefetch_stage_if ifc ();

  prefetch_stage dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .flush_target       (flush_target),
    .br_redirect        (br_redirect),
    .br_redirect_target (br_redirect_target),
    .user_mode          (user_mode),
    .pfs_if             (ifc.master),
    .o_dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    flush              = 1'b0;
    flush_target       = '0;
    br_redirect        = 1'b0;
    br_redirect_target = '0;
    user_mode          = 1'b0;
  endtask

  task automatic test_reset();
    prefetch_to_fetch_bus_t zero_bus;
    zero_bus = '0;
    reset = 1'b1;
    drive_idle();
    ifc.fs_allowin     = 1'b1;
    ifc.icache_addr_ok = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", ifc.icache_req); end
    checks++; if (ifc.pfs_to_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ifc.pfs_to_valid); end
    checks++; if (ifc.prefetch_to_fetch_bus1 !== zero_bus) begin failures++; $display("FAIL rst_bus1 got=%h exp=0", ifc.prefetch_to_fetch_bus1); end
    checks++; if (ifc.prefetch_to_fetch_bus2 !== zero_bus) begin failures++; $display("FAIL rst_bus2 got=%h exp=0", ifc.prefetch_to_fetch_bus2); end
    checks++; if (dbg_state !== S_BOOT) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_BOOT); end
    // First cycle out of reset is S_BOOT: still silent.
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL boot_req got=%b exp=0", ifc.icache_req); end
    checks++; if (ifc.pfs_to_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", ifc.pfs_to_valid); end
    checks++; if (ifc.prefetch_to_fetch_bus2 !== zero_bus) begin failures++; $display("FAIL boot_bus2 got=%h exp=0", ifc.prefetch_to_fetch_bus2); end
  endtask

  task automatic test_sequential();
    virt_t exp_addr [3];
    exp_addr[0] = 32'hBFC0_0000;
    exp_addr[1] = 32'hBFC0_0008;
    exp_addr[2] = 32'hBFC0_0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (ifc.icache_addr !== exp_addr[i]) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, ifc.icache_addr, exp_addr[i]); end
      checks++; if (ifc.icache_req !== 1'b1) begin failures++; $display("FAIL seq_req%0d got=%b exp=1", i, ifc.icache_req); end
      checks++; if (ifc.pfs_to_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, ifc.pfs_to_valid); end
      checks++; if (ifc.prefetch_to_fetch_bus2.pc !== (exp_addr[i] | 32'h4)) begin failures++; $display("FAIL seq_bus2pc%0d got=%h exp=%h", i, ifc.prefetch_to_fetch_bus2.pc, exp_addr[i] | 32'h4); end
      checks++; if (ifc.prefetch_to_fetch_bus1.valid !== 1'b1) begin failures++; $display("FAIL seq_bus1v%0d got=%b exp=1", i, ifc.prefetch_to_fetch_bus1.valid); end
    end
    // pc_r now 0xBFC00018
  endtask

  task automatic test_unaligned_redirect();
    @(negedge clk);
    br_redirect        = 1'b1;
    br_redirect_target = 32'h8000_1004;
    #1;
    checks++; if (ifc.pfs_to_valid !== 1'b1) begin failures++; $display("FAIL redir_same_cycle_valid got=%b exp=1", ifc.pfs_to_valid); end
    checks++; if (ifc.icache_addr !== 32'hBFC0_0018) begin failures++; $display("FAIL redir_same_cycle_addr got=%h exp=bfc00018", ifc.icache_addr); end
    @(negedge clk);
    br_redirect = 1'b0;
    #1;
    checks++; if (ifc.prefetch_to_fetch_bus1.valid !== 1'b0) begin failures++; $display("FAIL redir_bus1v got=%b exp=0", ifc.prefetch_to_fetch_bus1.valid); end
    checks++; if (ifc.prefetch_to_fetch_bus2.pc !== 32'h8000_1004) begin failures++; $display("FAIL redir_bus2pc got=%h exp=80001004", ifc.prefetch_to_fetch_bus2.pc); end
    checks++; if (ifc.prefetch_to_fetch_bus2.valid !== 1'b1) begin failures++; $display("FAIL redir_bus2v got=%b exp=1", ifc.prefetch_to_fetch_bus2.valid); end
    checks++; if (ifc.icache_addr !== 32'h8000_1000) begin failures++; $display("FAIL redir_addr got=%h exp=80001000", ifc.icache_addr); end
    checks++; if (ifc.prefetch_to_fetch_bus1.exception.ex !== 1'b0) begin failures++; $display("FAIL redir_ex got=%b exp=0", ifc.prefetch_to_fetch_bus1.exception.ex); end
    // pc_r now 0x80001008
  endtask

  task automatic test_misaligned_flush();
    @(negedge clk);
    flush        = 1'b1;
    flush_target = 32'h8000_0002;
    #1;
    checks++; if (ifc.pfs_to_valid !== 1'b0) begin failures++; $display("FAIL mflush_cycle_valid got=%b exp=0", ifc.pfs_to_valid); end
    checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL mflush_cycle_req got=%b exp=0", ifc.icache_req); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL adel_req got=%b exp=0", ifc.icache_req); end
    checks++; if (ifc.pfs_to_valid !== 1'b1) begin failures++; $display("FAIL adel_valid got=%b exp=1", ifc.pfs_to_valid); end
    checks++; if (ifc.prefetch_to_fetch_bus1.exception.ex !== 1'b1) begin failures++; $display("FAIL adel_ex1 got=%b exp=1", ifc.prefetch_to_fetch_bus1.exception.ex); end
    checks++; if (ifc.prefetch_to_fetch_bus2.exception.ex !== 1'b1) begin failures++; $display("FAIL adel_ex2 got=%b exp=1", ifc.prefetch_to_fetch_bus2.exception.ex); end
    checks++; if (ifc.prefetch_to_fetch_bus1.exception.exccode !== 5'h04) begin failures++; $display("FAIL adel_code got=%h exp=04", ifc.prefetch_to_fetch_bus1.exception.exccode); end
    checks++; if (ifc.prefetch_to_fetch_bus2.exception.badvaddr !== 32'h8000_0002) begin failures++; $display("FAIL adel_badva got=%h exp=80000002", ifc.prefetch_to_fetch_bus2.exception.badvaddr); end
    checks++; if (ifc.prefetch_to_fetch_bus1.exception.tlb_refill !== 1'b0) begin failures++; $display("FAIL adel_refill got=%b exp=0", ifc.prefetch_to_fetch_bus1.exception.tlb_refill); end
    // Errored pair still advances: pc_r now 0x80000008
  endtask

  task automatic test_flush_redirect_waiting();
    @(negedge clk);
    ifc.icache_addr_ok = 1'b0;
    #1;
    checks++; if (ifc.icache_req !== 1'b1) begin failures++; $display("FAIL wait_req got=%b exp=1", ifc.icache_req); end
    checks++; if (ifc.pfs_to_valid !== 1'b0) begin failures++; $display("FAIL wait_valid got=%b exp=0", ifc.pfs_to_valid); end
    @(negedge clk);
    #1;
    checks++; if (ifc.icache_addr !== 32'h8000_0008) begin failures++; $display("FAIL wait_hold_addr got=%h exp=80000008", ifc.icache_addr); end
    flush              = 1'b1;
    flush_target       = 32'h8000_2000;
    br_redirect        = 1'b1;
    br_redirect_target = 32'h8000_3000;
    ifc.icache_addr_ok = 1'b1;
    #1;
    checks++; if (ifc.pfs_to_valid !== 1'b0) begin failures++; $display("FAIL fr_valid got=%b exp=0", ifc.pfs_to_valid); end
    checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL fr_req got=%b exp=0", ifc.icache_req); end
    @(negedge clk);
    flush       = 1'b0;
    br_redirect = 1'b0;
    #1;
    checks++; if (ifc.icache_addr !== 32'h8000_2000) begin failures++; $display("FAIL fr_next_addr got=%h exp=80002000", ifc.icache_addr); end
    checks++; if (ifc.pfs_to_valid !== 1'b1) begin failures++; $display("FAIL fr_next_valid got=%b exp=1", ifc.pfs_to_valid); end
    // pc_r now 0x80002008
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ifc.fs_allowin = 1'b0;
      #1;
      checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL bp_req%0d got=%b exp=0", i, ifc.icache_req); end
      checks++; if (ifc.pfs_to_valid !== 1'b0) begin failures++; $display("FAIL bp_valid%0d got=%b exp=0", i, ifc.pfs_to_valid); end
      checks++; if (ifc.icache_addr !== 32'h8000_2008) begin failures++; $display("FAIL bp_hold%0d got=%h exp=80002008", i, ifc.icache_addr); end
    end
    @(negedge clk);
    ifc.fs_allowin = 1'b1;
    #1;
    checks++; if (ifc.icache_req !== 1'b1) begin failures++; $display("FAIL bp_resume_req got=%b exp=1", ifc.icache_req); end
    checks++; if (ifc.icache_addr !== 32'h8000_2008) begin failures++; $display("FAIL bp_resume_addr got=%h exp=80002008", ifc.icache_addr); end
    checks++; if (ifc.pfs_to_valid !== 1'b1) begin failures++; $display("FAIL bp_resume_valid got=%b exp=1", ifc.pfs_to_valid); end
    // pc_r now 0x80002010
  endtask

  task automatic test_kseg();
    @(negedge clk);
    user_mode = 1'b1;
    #1;
`ifdef PFS_KSEG_CHECK_EN
    checks++; if (ifc.prefetch_to_fetch_bus1.exception.ex !== 1'b1) begin failures++; $display("FAIL kseg_ex got=%b exp=1", ifc.prefetch_to_fetch_bus1.exception.ex); end
    checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL kseg_req got=%b exp=0", ifc.icache_req); end
    checks++; if (ifc.prefetch_to_fetch_bus2.exception.badvaddr !== 32'h8000_2010) begin failures++; $display("FAIL kseg_badva got=%h exp=80002010", ifc.prefetch_to_fetch_bus2.exception.badvaddr); end
`else
    checks++; if (ifc.prefetch_to_fetch_bus1.exception.ex !== 1'b0) begin failures++; $display("FAIL kseg_ex got=%b exp=0", ifc.prefetch_to_fetch_bus1.exception.ex); end
    checks++; if (ifc.icache_req !== 1'b1) begin failures++; $display("FAIL kseg_req got=%b exp=1", ifc.icache_req); end
    checks++; if (ifc.icache_addr !== 32'h8000_2010) begin failures++; $display("FAIL kseg_addr got=%h exp=80002010", ifc.icache_addr); end
`endif
    checks++; if (ifc.pfs_to_valid !== 1'b1) begin failures++; $display("FAIL kseg_valid got=%b exp=1", ifc.pfs_to_valid); end
    @(negedge clk);
    user_mode = 1'b0;
  endtask

  task automatic test_wrap();
    flush        = 1'b1;
    flush_target = 32'hFFFF_FFF8;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (ifc.icache_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_top got=%h exp=fffffff8", ifc.icache_addr); end
    @(negedge clk);
    #1;
    checks++; if (ifc.icache_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_zero got=%h exp=00000000", ifc.icache_addr); end
    checks++; if (ifc.prefetch_to_fetch_bus1.exception.ex !== 1'b0) begin failures++; $display("FAIL wrap_ex got=%b exp=0", ifc.prefetch_to_fetch_bus1.exception.ex); end
    checks++; if (ifc.icache_req !== 1'b1) begin failures++; $display("FAIL wrap_req got=%b exp=1", ifc.icache_req); end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset              = 1'b1;
    flush              = 1'b1;
    flush_target       = 32'h8000_0000;
    br_redirect        = 1'b1;
    br_redirect_target = 32'h8000_4000;
    #1;
    checks++; if (ifc.pfs_to_valid !== 1'b0) begin failures++; $display("FAIL rprio_valid got=%b exp=0", ifc.pfs_to_valid); end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    checks++; if (dbg_state !== S_BOOT) begin failures++; $display("FAIL rprio_state got=%0d exp=%0d", dbg_state, S_BOOT); end
    checks++; if (ifc.icache_req !== 1'b0) begin failures++; $display("FAIL rprio_boot_req got=%b exp=0", ifc.icache_req); end
    @(negedge clk);
    #1;
    checks++; if (ifc.icache_addr !== PFS_RESET_PC) begin failures++; $display("FAIL rprio_addr got=%h exp=bfc00000", ifc.icache_addr); end
    checks++; if (ifc.icache_req !== 1'b1) begin failures++; $display("FAIL rprio_req got=%b exp=1", ifc.icache_req); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_unaligned_redirect();
    test_misaligned_flush();
    test_flush_redirect_waiting();
    test_backpressure();
    test_kseg();
    test_wrap();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
